// File: rtl/divisor_scheduler_if.sv
// Requester, response and divider-side signals of divisor_scheduler.
// slave = scheduler side, master = requesters plus attached divider.
interface divisor_scheduler_if #(
  parameter int tamanyo = 32,
  parameter int NREQ    = 4
);
  logic [NREQ-1:0]         req_valid;
  logic [NREQ-1:0]         req_ready;
  logic [NREQ*tamanyo-1:0] req_num;
  logic [NREQ*tamanyo-1:0] req_den;
  logic [NREQ-1:0]         rsp_valid;
  logic [tamanyo-1:0]      rsp_coc;
  logic [tamanyo-1:0]      rsp_res;
  logic                    rsp_err;
  logic                    sync_err;
  logic                    div_start;
  logic [tamanyo-1:0]      div_num;
  logic [tamanyo-1:0]      div_den;
  logic [tamanyo-1:0]      div_coc;
  logic [tamanyo-1:0]      div_res;
  logic                    div_done;

  modport slave (
    input  req_valid, req_num, req_den,
    input  div_coc, div_res, div_done,
    output req_ready, rsp_valid, rsp_coc, rsp_res,
    output rsp_err, sync_err,
    output div_start, div_num, div_den
  );

  modport master (
    output req_valid, req_num, req_den,
    output div_coc, div_res, div_done,
    input  req_ready, rsp_valid, rsp_coc, rsp_res,
    input  rsp_err, sync_err,
    input  div_start, div_num, div_den
  );
endinterface

// File: rtl/divisor_scheduler.sv
// Round-robin scheduler sharing one pipelined divider among NREQ requesters.
// Define DIVSCHED_DIV0_CHECK_EN to force a fixed result on divide-by-zero.
module divisor_scheduler #(
  parameter int tamanyo = 32,
  parameter int NREQ    = 4,
  parameter int MAX_OUT = 4
) (
  input logic          CLK,
  input logic          RSTa,
  divisor_scheduler_if.slave bus
);
  localparam int LAT = 2*tamanyo+1;
  localparam int IDW = $clog2(NREQ);
  localparam int CW  = $clog2(MAX_OUT+1);
  localparam logic [CW-1:0]  MAXC = CW'(MAX_OUT);
  localparam logic [IDW-1:0] LASTI = IDW'(NREQ-1);

`ifdef DIVSCHED_DIV0_CHECK_EN
  typedef struct packed {
    logic           v;
    logic [IDW-1:0] id;
    logic           z;
  } tag_t;
`else
  typedef struct packed {
    logic           v;
    logic [IDW-1:0] id;
  } tag_t;
`endif

  tag_t [LAT-1:0]          tag_q, tag_d;
  tag_t                    new_tag;
  logic [NREQ-1:0][CW-1:0] cnt_q, cnt_d;
  logic [IDW-1:0]          ptr_q, ptr_d;
  logic                    sync_err_q, sync_err_d;
  logic [NREQ-1:0]         elig, gnt, rsp;
  logic [IDW-1:0]          gid, idx;
  logic                    found, hit;
  logic [tamanyo-1:0]      num, den;

  // Tag head owns whatever the divider retires this cycle
  always_comb begin
    rsp = '0;
    hit = bus.div_done & tag_q[0].v;
    if (hit) rsp[tag_q[0].id] = 1'b1;
  end

  // A credit freed by this cycle's response is usable immediately
  always_comb begin
    elig = '0;
    for (int i = 0; i < NREQ; i++)
      elig[i] = RSTa & bus.req_valid[i] &
                ((cnt_q[i] < MAXC) | rsp[i]);
  end

  always_comb begin
    gnt   = '0;
    gid   = ptr_q;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = IDW'((int'(ptr_q) + k) % NREQ);
      if (!found && elig[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gid      = idx;
      end
    end
  end

  always_comb begin
    num = '0;
    den = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        num = bus.req_num[i*tamanyo +: tamanyo];
        den = bus.req_den[i*tamanyo +: tamanyo];
      end
    end
  end

  always_comb begin
    new_tag    = '0;
    new_tag.v  = found;
    new_tag.id = gid;
`ifdef DIVSCHED_DIV0_CHECK_EN
    new_tag.z  = found & (den == '0);
`endif
    tag_d      = {new_tag, tag_q[LAT-1:1]};
    ptr_d      = found ? gid : ptr_q;
    sync_err_d = sync_err_q | (bus.div_done != tag_q[0].v);
    for (int i = 0; i < NREQ; i++)
      cnt_d[i] = cnt_q[i] + CW'(gnt[i]) - CW'(rsp[i]);
  end

  always_comb begin
    bus.req_ready = gnt;
    bus.div_start = found;
    bus.div_num   = num;
    bus.div_den   = den;
    bus.rsp_valid = rsp;
    bus.rsp_coc   = hit ? bus.div_coc : '0;
    bus.rsp_res   = hit ? bus.div_res : '0;
    bus.rsp_err   = 1'b0;
    bus.sync_err  = sync_err_q;
`ifdef DIVSCHED_DIV0_CHECK_EN
    if (hit && tag_q[0].z) begin
      bus.rsp_coc = '1;
      bus.rsp_res = '0;
      bus.rsp_err = 1'b1;
    end
`endif
  end

  always_ff @(posedge CLK or negedge RSTa) begin
    if (!RSTa) begin
      tag_q      <= '0;
      cnt_q      <= '0;
      ptr_q      <= LASTI;
      sync_err_q <= 1'b0;
    end else begin
      tag_q      <= tag_d;
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
      sync_err_q <= sync_err_d;
    end
  end
endmodule
